// File: rtl/cp0_unit.sv
// cp0_unit: MIPS coprocessor-0 state (SR, Cause, EPC, PRId).
// Resolves interrupts/exceptions at commit and redirects the PC.
module cp0_unit #(
  parameter logic [31:0] PRID_VAL = 32'h2022_0707
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_in,
  output logic [31:0] cp0_out,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic        exl_clr,
  output logic        req,
  output logic [31:0] epc_out
);

  localparam logic [4:0] A_SR    = 5'd12;
  localparam logic [4:0] A_CAUSE = 5'd13;
  localparam logic [4:0] A_EPC   = 5'd14;
  localparam logic [4:0] A_PRID  = 5'd15;

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic        wr_ok;

  // Commit-point trap decision; EXL blocks nesting
  always_comb begin
    int_req = (|(hw_int & im)) & ie & ~exl;
    exc_req = (exc_code_in != 5'd0) & ~exl;
    req     = (int_req | exc_req) & ~reset;
    wr_ok   = en & ~req & ~exl_clr;
  end

  // SR: trap sets EXL, eret clears it, mtc0 loads it last
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im  <= '0;
      exl <= 1'b0;
      ie  <= 1'b0;
    end else if (req) begin
      exl <= 1'b1;
    end else if (exl_clr) begin
      exl <= 1'b0;
    end else if (wr_ok && cp0_addr == A_SR) begin
      im  <= cp0_in[15:10];
      exl <= cp0_in[1];
      ie  <= cp0_in[0];
    end
  end

  // Cause: IP samples the pins, BD/ExcCode record the trap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bd       <= 1'b0;
      ip       <= '0;
      exc_code <= '0;
    end else begin
      ip <= hw_int;
      if (req) begin
        bd       <= bd_in;
        exc_code <= int_req ? 5'd0 : exc_code_in;
      end
    end
  end

  // EPC: restart address on trap (branch for delay slots)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      epc <= '0;
    end else if (req) begin
      epc <= bd_in ? vpc - 32'd4 : vpc;
    end else if (wr_ok && cp0_addr == A_EPC) begin
      epc <= cp0_in;
    end
  end

  // mfc0 read mux, no bypass of same-cycle writes
  always_comb begin
    cp0_out = '0;
    case (cp0_addr)
      A_SR:    cp0_out = {16'b0, im, 8'b0, exl, ie};
      A_CAUSE: cp0_out = {bd, 15'b0, ip, 3'b0, exc_code, 2'b0};
      A_EPC:   cp0_out = epc;
      A_PRID:  cp0_out = PRID_VAL;
      default: cp0_out = '0;
    endcase
  end

  assign epc_out = epc;

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: vector table, corner sequences and random run
// checked against a register-word model of CP0.
module tb_cp0_unit;

  localparam logic [31:0] PRID = 32'h2022_0707;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_in;
  logic [31:0] cp0_out;
  logic [31:0] vpc;
  logic        bd_in;
  logic [4:0]  exc_code_in;
  logic [5:0]  hw_int;
  logic        exl_clr;
  logic        req;
  logic [31:0] epc_out;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_sr    = '0;
  logic [31:0] m_cause = '0;
  logic [31:0] m_epc   = '0;

  cp0_unit dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .cp0_addr(cp0_addr),
    .cp0_in(cp0_in),
    .cp0_out(cp0_out),
    .vpc(vpc),
    .bd_in(bd_in),
    .exc_code_in(exc_code_in),
    .hw_int(hw_int),
    .exl_clr(exl_clr),
    .req(req),
    .epc_out(epc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        e;
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] v;
    logic        b;
    logic [4:0]  x;
    logic [5:0]  h;
    logic        c;
    logic        q;
    logic [31:0] o;
    logic [31:0] p;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic m_int();
    return (|(hw_int & m_sr[15:10])) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_exc();
    return (exc_code_in != 0) && !m_sr[1];
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_update();
    logic ir, xr;
    ir = m_int();
    xr = m_exc();
    if (reset) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
      return;
    end
    if (ir || xr) begin
      m_sr[1] = 1'b1;
      m_cause[31] = bd_in;
      m_cause[6:2] = ir ? 5'd0 : exc_code_in;
      m_epc = bd_in ? vpc - 32'd4 : vpc;
    end else if (exl_clr) begin
      m_sr[1] = 1'b0;
    end else if (en) begin
      if (cp0_addr == 5'd12) m_sr = cp0_in & 32'h0000_FC03;
      if (cp0_addr == 5'd14) m_epc = cp0_in;
    end
    m_cause[15:10] = hw_int;
  endtask

  task automatic drive(input logic e, input logic [4:0] a,
                       input logic [31:0] d, input logic [31:0] v,
                       input logic b, input logic [4:0] x,
                       input logic [5:0] h, input logic c);
    en = e; cp0_addr = a; cp0_in = d; vpc = v;
    bd_in = b; exc_code_in = x; hw_int = h; exl_clr = c;
  endtask

  task automatic model_check();
    chk("m_req", {31'b0, req}, {31'b0, (m_int() || m_exc())});
    chk("m_cp0_out", cp0_out, m_read(cp0_addr));
    chk("m_epc_out", epc_out, m_epc);
  endtask

  task automatic tick();
    @(posedge clk);
    m_update();
    #1;
  endtask

  task automatic sync_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    m_sr = 0; m_cause = 0; m_epc = 0;
    #1;
    reset = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1,12,32'h401,0,0,0,0,0, 0,32'h0,32'h0};
    tbl[1]  = '{0,12,0,32'h3010,0,0,1,0, 1,32'h401,32'h0};
    tbl[2]  = '{0,13,0,32'h3014,0,0,1,0, 0,32'h400,32'h3010};
    tbl[3]  = '{0,12,0,0,0,0,1,1, 0,32'h403,32'h3010};
    tbl[4]  = '{0,12,0,32'h3100,0,0,1,0, 1,32'h401,32'h3010};
    tbl[5]  = '{0,14,0,0,0,0,0,1, 0,32'h3100,32'h3100};
    tbl[6]  = '{0,12,0,32'h3024,1,10,0,0, 1,32'h401,32'h3100};
    tbl[7]  = '{1,13,32'hFFFF_FFFF,0,0,0,0,0,
                0,32'h8000_0028,32'h3020};
    tbl[8]  = '{1,14,32'hDEAD,0,0,0,0,1, 0,32'h3020,32'h3020};
    tbl[9]  = '{0,13,0,0,0,0,0,0, 0,32'h8000_0028,32'h3020};
    tbl[10] = '{1,14,32'hBEEF,32'h3200,0,12,1,0,
                1,32'h3020,32'h3020};
    tbl[11] = '{0,13,0,0,0,0,0,0, 0,32'h400,32'h3200};
    tbl[12] = '{0,14,0,0,0,5,0,0, 0,32'h3200,32'h3200};
    tbl[13] = '{0,15,0,0,0,0,0,0, 0,PRID,32'h3200};
    tbl[14] = '{0,7,0,0,0,0,0,0, 0,32'h0,32'h3200};
    tbl[15] = '{0,12,0,0,0,0,0,1, 0,32'h403,32'h3200};

    reset = 1'b1;
    drive(0, 12, 0, 32'h3000, 0, 3, 6'h3F, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'b0, req}, 32'h0);
    drive(0, 12, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #3;
    chk("rst_sr", cp0_out, 32'h0);
    chk("rst_epc", epc_out, 32'h0);
    chk("rst_req2", {31'b0, req}, 32'h0);
    cp0_addr = 13; #1;
    chk("rst_cause", cp0_out, 32'h0);
    cp0_addr = 15; #1;
    chk("rst_prid", cp0_out, PRID);
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].e, tbl[i].a, tbl[i].d, tbl[i].v,
            tbl[i].b, tbl[i].x, tbl[i].h, tbl[i].c);
      #3;
      chk($sformatf("vec%0d_req", i), {31'b0, req}, {31'b0, tbl[i].q});
      chk($sformatf("vec%0d_out", i), cp0_out, tbl[i].o);
      chk($sformatf("vec%0d_epc", i), epc_out, tbl[i].p);
      model_check();
      tick();
    end

    sync_reset();
    drive(1, 12, 32'h400, 0, 0, 0, 1, 0);
    #3;
    chk("ie_off_req", {31'b0, req}, 32'h0);
    model_check();
    tick();
    drive(1, 12, 32'h401, 0, 0, 0, 1, 0);
    #3;
    chk("ie_set_req", {31'b0, req}, 32'h0);
    model_check();
    tick();
    drive(0, 12, 0, 32'h3040, 0, 0, 1, 0);
    #3;
    chk("ie_next_req", {31'b0, req}, 32'h1);
    model_check();
    tick();
    drive(0, 12, 0, 32'h3050, 0, 3, 1, 0);
    #3;
    chk("hdl_exl", cp0_out, 32'h403);
    chk("hdl_epc", epc_out, 32'h3040);
    chk("hdl_req", {31'b0, req}, 32'h0);
    reset = 1'b1;
    #1;
    chk("async_epc", epc_out, 32'h0);
    chk("async_sr", cp0_out, 32'h0);
    chk("async_req", {31'b0, req}, 32'h0);
    m_sr = 0; m_cause = 0; m_epc = 0;
    @(posedge clk);
    #2;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #3;
    model_check();
    tick();

    for (int i = 0; i < 400; i++) begin
      logic [4:0] a;
      logic [31:0] d;
      a = ($urandom_range(0, 7) < 4) ? 5'(12 + $urandom_range(0, 3))
                                     : 5'($urandom_range(0, 31));
      d = $urandom;
      drive($urandom_range(0, 3) == 0, a, d, $urandom & 32'hFFFF_FFFC,
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31)) : 5'd0,
            ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'd0,
            $urandom_range(0, 3) == 0);
      #3;
      model_check();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
